// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Brief    : SPI mode-0 target that emulates a serial boot flash. It serves
//            READ (0x03) requests from a byte-wide memory that is preloaded
//            through a simple write port while no transaction is open.
// Options  : define SPI_FAST_READ_EN to also accept FAST READ (0x0B), which
//            inserts 8 dummy clocks between the address and the data.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12     // log2(DEPTH); must be at least 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ss,
  input  logic              spi_clk,
  input  logic              mosi,
  output logic              miso,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              cmd_err,
  output logic [15:0]       tx_count
);

  localparam logic [2:0] C_ST_IDLE   = 3'd0;
  localparam logic [2:0] C_ST_CMD    = 3'd1;
  localparam logic [2:0] C_ST_ADDR   = 3'd2;
  localparam logic [2:0] C_ST_DATA   = 3'd3;
  localparam logic [2:0] C_ST_IGNORE = 3'd4;
  localparam logic [7:0] C_OP_READ   = 8'h03;
`ifdef SPI_FAST_READ_EN
  localparam logic [2:0] C_ST_DUMMY  = 3'd5;
  localparam logic [7:0] C_OP_FAST   = 8'h0B;
`endif

  // Synchroniser pipes: [0] first flop, [1] synchronised value, [2] previous.
  // ss resets to 0 so a select held low across reset release is not
  // mistaken for a new falling edge.
  logic [2:0]        ss_pipe_q, ss_pipe_d;
  logic [2:0]        sclk_pipe_q, sclk_pipe_d;
  logic [1:0]        mosi_pipe_q, mosi_pipe_d;

  logic [2:0]        state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-2:0] shift_q, shift_d;    // upper address bits never kept
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              miso_q, miso_d;
  logic              cmd_err_q, cmd_err_d;
  logic [15:0]       tx_count_q, tx_count_d;
`ifdef SPI_FAST_READ_EN
  logic              fast_q, fast_d;
`endif

  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_data_q;

  logic              w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_mosi;
  logic              w_op_ok;
  logic [7:0]        w_opcode;
  logic [ADDR_W-1:0] w_addr_next;

  assign w_ss_fall   = ~ss_pipe_q[1] &  ss_pipe_q[2];
  assign w_ss_rise   =  ss_pipe_q[1] & ~ss_pipe_q[2];
  assign w_sclk_rise =  sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign w_sclk_fall = ~sclk_pipe_q[1] &  sclk_pipe_q[2];
  assign w_mosi      = mosi_pipe_q[1];
  assign w_opcode    = {shift_q[6:0], w_mosi};
  assign w_addr_next = {shift_q, w_mosi};
`ifdef SPI_FAST_READ_EN
  assign w_op_ok     = (w_opcode == C_OP_READ) || (w_opcode == C_OP_FAST);
`else
  assign w_op_ok     = (w_opcode == C_OP_READ);
`endif

  // Shift the asynchronous SPI inputs into their synchroniser pipes.
  always_comb begin
    ss_pipe_d   = {ss_pipe_q[1:0], ss};
    sclk_pipe_d = {sclk_pipe_q[1:0], spi_clk};
    mosi_pipe_d = {mosi_pipe_q[0], mosi};
  end

  // Next-state logic; a select release always wins over a coincident edge.
  always_comb begin
    state_d = state_q;
    if (state_q != C_ST_IDLE && w_ss_rise) begin
      state_d = C_ST_IDLE;
    end else begin
      case (state_q)
        C_ST_IDLE:   if (w_ss_fall) state_d = C_ST_CMD;
        C_ST_CMD:    if (w_sclk_rise && bit_cnt_q == 5'd7)
                       state_d = w_op_ok ? C_ST_ADDR : C_ST_IGNORE;
`ifdef SPI_FAST_READ_EN
        C_ST_ADDR:   if (w_sclk_rise && bit_cnt_q == 5'd23)
                       state_d = fast_q ? C_ST_DUMMY : C_ST_DATA;
        C_ST_DUMMY:  if (w_sclk_rise && bit_cnt_q == 5'd7) state_d = C_ST_DATA;
`else
        C_ST_ADDR:   if (w_sclk_rise && bit_cnt_q == 5'd23) state_d = C_ST_DATA;
`endif
        C_ST_DATA:   state_d = C_ST_DATA;
        C_ST_IGNORE: state_d = C_ST_IGNORE;
        default:     state_d = C_ST_IDLE;
      endcase
    end
  end

  // Datapath and output updates for each state.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_sr_d    = tx_sr_q;
    ptr_d      = ptr_q;
    miso_d     = (state_q == C_ST_DATA) ? miso_q : 1'b0;
    cmd_err_d  = 1'b0;
    tx_count_d = tx_count_q;
`ifdef SPI_FAST_READ_EN
    fast_d     = fast_q;
`endif
    if (state_q != C_ST_IDLE && w_ss_rise) begin
      miso_d    = 1'b0;
      bit_cnt_d = 5'd0;
    end else begin
      case (state_q)
        C_ST_IDLE: begin
          if (w_ss_fall) begin
            bit_cnt_d  = 5'd0;
            shift_d    = '0;
            tx_count_d = 16'd0;
          end
        end
        C_ST_CMD: begin
          if (w_sclk_rise) begin
            shift_d = {shift_q[ADDR_W-3:0], w_mosi};
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              cmd_err_d = ~w_op_ok;
`ifdef SPI_FAST_READ_EN
              fast_d    = (w_opcode == C_OP_FAST);
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        C_ST_ADDR: begin
          if (w_sclk_rise) begin
            shift_d = {shift_q[ADDR_W-3:0], w_mosi};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = 5'd0;
              ptr_d     = w_addr_next;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
`ifdef SPI_FAST_READ_EN
        C_ST_DUMMY: begin
          if (w_sclk_rise)
            bit_cnt_d = (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
        end
`endif
        C_ST_DATA: begin
          if (w_sclk_fall) begin
            if (bit_cnt_q[2:0] == 3'd0) begin
              tx_sr_d = rd_data_q;
              miso_d  = rd_data_q[7];
              ptr_d   = ptr_q + ADDR_W'(1);
              if (tx_count_q != 16'hFFFF) tx_count_d = tx_count_q + 16'd1;
            end else begin
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
              miso_d  = tx_sr_q[6];
            end
            bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
          end
        end
        default: miso_d = 1'b0;
      endcase
    end
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_pipe_q   <= 3'b000;
      sclk_pipe_q <= 3'b000;
      mosi_pipe_q <= 2'b00;
      state_q     <= C_ST_IDLE;
      bit_cnt_q   <= 5'd0;
      shift_q     <= '0;
      tx_sr_q     <= 8'd0;
      ptr_q       <= '0;
      miso_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      tx_count_q  <= 16'd0;
`ifdef SPI_FAST_READ_EN
      fast_q      <= 1'b0;
`endif
    end else begin
      ss_pipe_q   <= ss_pipe_d;
      sclk_pipe_q <= sclk_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_sr_q     <= tx_sr_d;
      ptr_q       <= ptr_d;
      miso_q      <= miso_d;
      cmd_err_q   <= cmd_err_d;
      tx_count_q  <= tx_count_d;
`ifdef SPI_FAST_READ_EN
      fast_q      <= fast_d;
`endif
    end
  end

  // Byte memory: preload only while idle, registered read of the pointer.
  always_ff @(posedge clk) begin
    if (load_we && state_q == C_ST_IDLE) mem[load_addr] <= load_data;
    rd_data_q <= mem[ptr_q];
  end

  assign miso     = miso_q;
  assign busy     = (state_q != C_ST_IDLE);
  assign cmd_err  = cmd_err_q;
  assign tx_count = tx_count_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Brief    : Self-checking bench for spi_flash_responder: a table of read
//            frames plus hand-written partial-frame and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  localparam int C_HALF = 5;   // clk cycles per SPI half period

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ss = 1'b1;
  logic        spi_clk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic        load_we = 1'b0;
  logic [11:0] load_addr = 12'd0;
  logic [7:0]  load_data = 8'd0;
  logic        busy;
  logic        cmd_err;
  logic [15:0] tx_count;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  spi_flash_responder #(.DEPTH(4096), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .ss(ss), .spi_clk(spi_clk), .mosi(mosi),
    .miso(miso), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .busy(busy), .cmd_err(cmd_err),
    .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  // Count clk cycles during which cmd_err is high.
  always @(negedge clk) if (cmd_err) err_pulses++;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] addr;
    logic        dummy;
    logic [15:0] exp_data;
    logic [1:0]  exp_err;
    logic [15:0] exp_tx;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    load_addr = a;
    load_data = d;
    load_we   = 1'b1;
    @(negedge clk);
    load_we   = 1'b0;
  endtask

  // Clock n bits MSB first; if end_frame, ss rises together with the last fall.
  task automatic spi_bits(input logic [7:0] tx, input int n, input bit end_frame,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      wait_clks(C_HALF);
      rx = {rx[6:0], miso};
      spi_clk = 1'b1;
      wait_clks(C_HALF);
      spi_clk = 1'b0;
      if (end_frame && i == n - 1) ss = 1'b1;
    end
  endtask

  task automatic read_frame(input string name, input logic [7:0] op, input logic [23:0] addr,
                            input bit dummy, input int nbytes, output logic [31:0] data);
    logic [7:0] rx;
    data = 32'd0;
    ss = 1'b0;
    wait_clks(4);
    err_pulses = 0;
    spi_bits(op, 8, 1'b0, rx);
    spi_bits(addr[23:16], 8, 1'b0, rx);
    spi_bits(addr[15:8], 8, 1'b0, rx);
    spi_bits(addr[7:0], 8, 1'b0, rx);
    if (dummy) spi_bits(8'h00, 8, 1'b0, rx);
    for (int b = 0; b < nbytes; b++) begin
      spi_bits(8'h00, 8, (b == nbytes - 1), rx);
      data = {data[23:0], rx};
    end
    wait_clks(3);
    check({name, " busy after ss high"}, {31'd0, busy}, 32'd0);
    wait_clks(4);
  endtask

  initial begin
    logic [31:0] data;
    logic [7:0]  r0, r1;

    vecs[0] = '{op:8'h03, addr:24'h000010, dummy:1'b0, exp_data:16'hA53C, exp_err:2'd0, exp_tx:16'd2};
    vecs[1] = '{op:8'h03, addr:24'h000012, dummy:1'b0, exp_data:16'h0FF0, exp_err:2'd0, exp_tx:16'd2};
    vecs[2] = '{op:8'h03, addr:24'h000FFF, dummy:1'b0, exp_data:16'h1122, exp_err:2'd0, exp_tx:16'd2};
    vecs[3] = '{op:8'h03, addr:24'hAB0FFF, dummy:1'b0, exp_data:16'h1122, exp_err:2'd0, exp_tx:16'd2};
    vecs[4] = '{op:8'h9F, addr:24'h000010, dummy:1'b0, exp_data:16'h0000, exp_err:2'd1, exp_tx:16'd0};
`ifdef SPI_FAST_READ_EN
    vecs[5] = '{op:8'h0B, addr:24'h000010, dummy:1'b1, exp_data:16'hA53C, exp_err:2'd0, exp_tx:16'd2};
`else
    vecs[5] = '{op:8'h0B, addr:24'h000010, dummy:1'b0, exp_data:16'h0000, exp_err:2'd1, exp_tx:16'd0};
`endif

    // Reset state.
    wait_clks(5);
    check("reset miso", {31'd0, miso}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset cmd_err", {31'd0, cmd_err}, 32'd0);
    check("reset tx_count", {16'd0, tx_count}, 32'd0);
    reset = 1'b0;
    wait_clks(5);

    preload(12'h010, 8'hA5);
    preload(12'h011, 8'h3C);
    preload(12'h012, 8'h0F);
    preload(12'h013, 8'hF0);
    preload(12'hFFF, 8'h11);
    preload(12'h000, 8'h22);
    preload(12'h001, 8'h77);
    wait_clks(2);

    // Four-byte read.
    read_frame("rd4", 8'h03, 24'h000010, 1'b0, 4, data);
    check("rd4 data", data, 32'hA53C0FF0);
    check("rd4 tx_count", {16'd0, tx_count}, 32'd4);
    check("rd4 cmd_err pulses", err_pulses, 32'd0);

    // Table-driven two-byte frames.
    for (int v = 0; v < 6; v++) begin
      read_frame($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].dummy, 2, data);
      check($sformatf("vec%0d data", v), data, {16'd0, vecs[v].exp_data});
      check($sformatf("vec%0d cmd_err pulses", v), err_pulses, {30'd0, vecs[v].exp_err});
      check($sformatf("vec%0d tx_count", v), {16'd0, tx_count}, {16'd0, vecs[v].exp_tx});
    end

    // Partial byte abort, with a preload attempted while busy.
    ss = 1'b0;
    wait_clks(4);
    spi_bits(8'h03, 8, 1'b0, r0);
    spi_bits(8'h00, 8, 1'b0, r0);
    spi_bits(8'h00, 8, 1'b0, r0);
    spi_bits(8'h10, 8, 1'b0, r0);
    check("abort busy in frame", {31'd0, busy}, 32'd1);
    preload(12'h011, 8'hEE);
    spi_bits(8'h00, 4, 1'b1, r0);
    wait_clks(3);
    check("abort busy after ss high", {31'd0, busy}, 32'd0);
    check("abort nibble", {28'd0, r0[3:0]}, 32'hA);
    wait_clks(4);
    check("abort tx_count", {16'd0, tx_count}, 32'd1);
    read_frame("after abort", 8'h03, 24'h000011, 1'b0, 1, data);
    check("after abort data", data, 32'h3C);

    // Reset during the address phase with ss held low.
    ss = 1'b0;
    wait_clks(4);
    spi_bits(8'h03, 8, 1'b0, r0);
    spi_bits(8'h00, 8, 1'b0, r0);
    reset = 1'b1;
    wait_clks(3);
    check("mid reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    wait_clks(3);
    spi_bits(8'h03, 8, 1'b0, r0);
    spi_bits(8'h00, 8, 1'b0, r1);
    check("post reset miso byte0", {24'd0, r0}, 32'd0);
    check("post reset miso byte1", {24'd0, r1}, 32'd0);
    check("post reset busy", {31'd0, busy}, 32'd0);
    ss = 1'b1;
    wait_clks(6);
    read_frame("fresh frame", 8'h03, 24'h000010, 1'b0, 1, data);
    check("fresh frame data", data, 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- SPI target that emulates a serial boot flash and answers the chip's SPI boot loader (the SPI master) over ss/spi_clk/mosi/miso.
- Serves bytes from an internal byte-wide memory that the bench or an FPGA-side host preloads through a simple write port.
- Used in system simulation and on the Nexys 4 as the external flash stand-in.

Parameters:
- DEPTH, 4096, memory size in bytes; power of two.
- ADDR_W, 12, log2(DEPTH); low address bits used for indexing.

Ports:
- clk  input  1  system clock; at least 8x spi_clk.
- reset  input  1  asynchronous, active-high reset.
- ss  input  1  SPI select, active-low, from the master.
- spi_clk  input  1  SPI clock, mode 0 (idle low, sample on rising edge).
- mosi  input  1  serial data from the master, MSB first.
- miso  output  1  serial data to the master, MSB first.
- load_we  input  1  preload write strobe.
- load_addr  input  ADDR_W  preload byte address.
- load_data  input  8  preload byte.
- busy  output  1  high while a transaction is in progress (state != IDLE).
- cmd_err  output  1  one-clk pulse when an unsupported opcode is received.
- tx_count  output  16  bytes sent in the current or last transaction; saturates at 16'hFFFF.

Behaviour:
- Reset values: miso=0, busy=0, cmd_err=0, tx_count=0, state=IDLE, shift/bit counters=0. Memory contents are not reset.
- Input synchronisation:
  - ss, spi_clk and mosi each pass through a 2-flop synchroniser.
  - Rising and falling edges of spi_clk are detected from the synchronised copy.
  - All protocol logic runs on clk.
- States: IDLE, CMD, ADDR, DATA, IGNORE (plus DUMMY with the optional feature).
- IDLE -> CMD on synchronised ss falling; bit counter cleared; tx_count cleared.
- CMD:
  - Shift mosi on 8 rising edges.
  - Opcode 8'h03 -> ADDR.
  - Any other opcode -> IGNORE, with cmd_err pulsed for one clk.
- ADDR:
  - Shift 24 address bits MSB first on rising edges.
  - Bits [ADDR_W-1:0] become the read pointer; upper bits are ignored.
  - After the 24th bit -> DATA.
- DATA:
  - On each spi_clk falling edge with bit index 0, load the shift register with mem[ptr], drive miso=bit7, increment ptr, and increment tx_count (saturating).
  - On subsequent falling edges, shift left and drive the next bit.
  - Memory read is registered. ptr is stable for at least 8 clk before use, so no stall exists.
- Pointer wrap: ptr wraps from DEPTH-1 to 0; the stream continues until ss deasserts.
- IGNORE: miso held 0; all edges ignored until ss rises.
- ss rising (synchronised) in any state:
  - Return to IDLE within 1 clk; miso=0; partial bytes discarded.
  - tx_count holds its value until the next ss falling edge.
- Simultaneous ss rising and spi_clk edge: ss rising wins; the edge is ignored.
- Preload port:
  - load_we writes mem[load_addr]=load_data in the same clk, only when state==IDLE.
  - Writes while busy are dropped.
- Reset mid-transaction: immediate return to reset values. The next transaction requires a fresh ss falling edge (ss already low at reset release is ignored until it goes high, then low).
- Latency: miso changes 3 clk after the physical spi_clk falling edge (2 synchroniser flops plus 1 register).

Optional Feature:
- Macro SPI_FAST_READ_EN.
- When defined:
  - Opcode 8'h0B is also accepted. ADDR -> DUMMY, which counts 8 rising edges (mosi ignored, miso=0), then -> DATA.
  - Data behaviour is identical to 8'h03.
- When undefined: 8'h0B is treated as unsupported -> IGNORE with a cmd_err pulse.

Test Plan:
- Preload mem[0x010..0x013]=A5,3C,0F,F0; master sends 03 00 00 10 and clocks 32 more bits -> miso returns A5 3C 0F F0; tx_count=4; cmd_err stays 0.
- Preload mem[0xFFF]=11, mem[0x000]=22; read from 0x000FFF for 2 bytes -> 11 then 22 (wrap); upper address byte 0xAB in 03 AB 0F FF gives the same result.
- Opcode 8'h9F -> cmd_err pulses exactly 1 clk, miso=0 for the rest of the frame, busy drops within 3 clk of ss high, tx_count=0.
- ss deasserted after 4 data bits of byte 0 from 0x000010, then a new 03 00 00 11 -> the first returned byte is 3C; load_we during the active frame does not change mem (read back unchanged).
- Assert reset during ADDR with ss held low, release, keep ss low and clock 16 bits -> miso=0, busy=0; a fresh ss high->low plus 03 00 00 10 -> A5.
- With SPI_FAST_READ_EN: 0B 00 00 10, 8 dummy clocks, 8 data clocks -> A5. Without the macro -> cmd_err pulse and miso=0.
